// File: rtl/dmem_bus_arbiter.sv
// Data-bus arbiter for two masters (m0 = cpu, m1 = aux) with mem/io decode and a fixed
// IDLE->ACCESS->ACK sequence. Define RR_ARB_EN for round-robin ties; otherwise m0 has priority.
module dmem_bus_arbiter #(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter logic [AW-1:0] IO_BASE = 32'h03000000,
  parameter int            IO_AW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [DW-1:0]    m0_wdata,
  output logic             m0_ack,
  output logic [DW-1:0]    m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m1_wdata,
  output logic             m1_ack,
  output logic [DW-1:0]    m1_rdata,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             io_we,
  output logic [IO_AW-1:0] io_addr,
  output logic [DW-1:0]    io_wdata,
  input  logic [DW-1:0]    io_rdata,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t          state;
  state_t          state_next;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            any_req;
  logic            grant;
  logic            sel_io;
  logic [DW-1:0]   capture;

  assign any_req = m0_req | m1_req;
  assign sel_io  = (lat_addr >= IO_BASE);
  assign capture = sel_io ? io_rdata : mem_rdata;

`ifdef RR_ARB_EN
  logic last_owner;

  // On a tie the master that did not win last time gets the bus.
  assign grant = (m0_req && m1_req) ? ~last_owner : m1_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_owner <= grant;
    end
  end
`else
  assign grant = ~m0_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      owner     <= grant;
      lat_we    <= grant ? m1_we    : m0_we;
      lat_addr  <= grant ? m1_addr  : m0_addr;
      lat_wdata <= grant ? m1_wdata : m0_wdata;
    end
  end

  // Read data is captured on every access, writes included, and held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ACCESS) begin
      if (owner) begin
        m1_rdata <= capture;
      end else begin
        m0_rdata <= capture;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    io_we      = 1'b0;
    io_addr    = '0;
    io_wdata   = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = ACK;
        if (sel_io) begin
          io_we    = lat_we;
          io_addr  = lat_addr[IO_AW-1:0];
          io_wdata = lat_wdata;
        end else begin
          mem_we    = lat_we;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
        end
      end
      ACK: begin
        state_next = IDLE;
        m0_ack     = ~owner;
        m1_ack     = owner;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: directed scenarios plus randomized two-master traffic
// scored against a transaction-level model of the bus (grant order, timing, memory contents).
module tb_dmem_bus_arbiter;

  localparam logic [31:0] IO_BASE = 32'h03000000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we, io_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, io_wdata, io_rdata;
  logic [4:0]  io_addr;

  int checks = 0;
  int errors = 0;

  dmem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Slave stand-ins: word-indexed data_mem and a 32-entry gpio file, preloaded with a pattern.
  logic [31:0] mem_arr [0:1023];
  logic [31:0] io_arr  [0:31];
  logic        slv_init = 1'b0;

  assign mem_rdata = mem_arr[mem_addr[11:2]];
  assign io_rdata  = io_arr[io_addr];

  always @(posedge clk) begin
    if (!slv_init) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'h10000000 | 32'(i);
      for (int i = 0; i < 32; i++) io_arr[i] <= 32'h20000000 | 32'(i);
      slv_init <= 1'b1;
    end else begin
      if (mem_we) mem_arr[mem_addr[11:2]] <= mem_wdata;
      if (io_we) io_arr[io_addr] <= io_wdata;
    end
  end

  // Reference view of memory contents and the transaction scheduler state.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_io  [logic [4:0]];
  logic        ref_last;
  tx_t         q0[$], q1[$];
  tx_t         cur [2];
  logic        act [2];
  int          gap [2];
  int          raise_cyc [2];
  int          cyc, next_free, exp_g, max_lat;
  logic        exp_valid, exp_own, exp_io;
  tx_t         exp_tx;
  logic [31:0] exp_rd;
  int          ack_order[$];

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (a >= IO_BASE) return ref_io.exists(a[4:0]) ? ref_io[a[4:0]] : (32'h20000000 | {27'h0, a[4:0]});
    return ref_mem.exists(a) ? ref_mem[a] : (32'h10000000 | {22'h0, a[11:2]});
  endfunction

  function automatic void refWrite(input logic [31:0] a, input logic [31:0] d);
    if (a >= IO_BASE) ref_io[a[4:0]] = d;
    else ref_mem[a] = d;
  endfunction

  function automatic tx_t mkTx(input logic we, input logic [31:0] a, input logic [31:0] d);
    tx_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic tx_t randTx();
    tx_t t;
    int  k;
    k = int'($urandom_range(4, 0));
    t.we    = 1'($urandom_range(1, 0));
    t.wdata = $urandom();
    if (k <= 1) t.addr = 32'($urandom_range(15, 0)) << 2;
    else if (k == 2) t.addr = IO_BASE + (32'($urandom_range(7, 0)) << 2);
    else if (k == 3) t.addr = 32'hFFFFFFE0 + (32'($urandom_range(7, 0)) << 2);
    else t.addr = IO_BASE - 32'd4;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp_v);
    checkOutput(tag, {31'h0, obs}, {31'h0, exp_v});
  endtask

  // Per-cycle master behaviour: hold req until ack, drop it, then present the next transaction.
  task automatic applyStimulus(input int max_gap);
    logic ackd [2];
    ackd[0] = m0_ack;
    ackd[1] = m1_ack;
    for (int m = 0; m < 2; m++) begin
      if (act[m]) begin
        if (ackd[m]) begin
          act[m] = 1'b0;
          gap[m] = int'($urandom_range(max_gap, 0));
        end
      end else if (gap[m] > 0) begin
        gap[m]--;
      end else if (m == 0 && q0.size() > 0) begin
        cur[0] = q0.pop_front(); act[0] = 1'b1; raise_cyc[0] = cyc;
      end else if (m == 1 && q1.size() > 0) begin
        cur[1] = q1.pop_front(); act[1] = 1'b1; raise_cyc[1] = cyc;
      end
    end
    m0_req = act[0]; m0_we = cur[0].we; m0_addr = cur[0].addr; m0_wdata = cur[0].wdata;
    m1_req = act[1]; m1_we = cur[1].we; m1_addr = cur[1].addr; m1_wdata = cur[1].wdata;
  endtask

  // Bus is free every third edge after a grant; a grant puts the strobe in the next
  // cycle and the ack in the one after.
  task automatic modelEdge(input int e);
    logic w;
    if (e >= next_free && (act[0] || act[1])) begin
      if (act[0] && act[1]) begin
`ifdef RR_ARB_EN
        w = ~ref_last;
`else
        w = 1'b0;
`endif
      end else begin
        w = act[1];
      end
      ref_last  = w;
      exp_valid = 1'b1;
      exp_g     = e;
      exp_own   = w;
      exp_tx    = cur[w];
      exp_io    = (cur[w].addr >= IO_BASE);
      if (cur[w].we) refWrite(cur[w].addr, cur[w].wdata);
      else exp_rd = refRead(cur[w].addr);
      next_free = e + 3;
    end
  endtask

  task automatic checkCycle(input int c);
    logic in_acc, in_ack;
    in_acc = exp_valid && (c == exp_g);
    in_ack = exp_valid && (c == exp_g + 1);
    checkBit("mem_we", mem_we, in_acc && exp_tx.we && !exp_io);
    checkBit("io_we", io_we, in_acc && exp_tx.we && exp_io);
    checkBit("busy", busy, in_acc || in_ack);
    checkBit("m0_ack", m0_ack, in_ack && !exp_own);
    checkBit("m1_ack", m1_ack, in_ack && exp_own);
    if (in_acc) begin
      checkBit("owner", owner, exp_own);
      checkOutput("mem_addr", mem_addr, exp_io ? 32'h0 : exp_tx.addr);
      checkOutput("mem_wdata", mem_wdata, exp_io ? 32'h0 : exp_tx.wdata);
      checkOutput("io_addr", {27'h0, io_addr}, exp_io ? {27'h0, exp_tx.addr[4:0]} : 32'h0);
      checkOutput("io_wdata", io_wdata, exp_io ? exp_tx.wdata : 32'h0);
    end
    if (in_ack) begin
      if (!exp_tx.we) checkOutput("rdata", exp_own ? m1_rdata : m0_rdata, exp_rd);
      ack_order.push_back(int'(exp_own));
      if (c - raise_cyc[exp_own] > max_lat) max_lat = c - raise_cyc[exp_own];
      exp_valid = 1'b0;
    end
  endtask

  task automatic runTraffic(input int max_gap, input int limit);
    cyc = 0; next_free = 0; exp_valid = 1'b0; max_lat = 0;
    gap[0] = 0; gap[1] = 0;
    ack_order.delete();
    while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || exp_valid || cyc + 1 < next_free)
           && cyc < limit) begin
      applyStimulus(max_gap);
      modelEdge(cyc + 1);
      @(negedge clk);
      cyc++;
      checkCycle(cyc);
    end
    checkOutput("traffic_drain", 32'(q0.size() + q1.size() + int'(act[0]) + int'(act[1])), 32'h0);
  endtask

  initial begin
    act[0] = 1'b0; act[1] = 1'b0;
    cur[0] = mkTx(1'b0, 32'h0, 32'h0); cur[1] = cur[0];
    ref_last = 1'b1;

    // Reset with both masters requesting: nothing may leave the arbiter.
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1111_1111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = IO_BASE; m1_wdata = 32'h2222_2222;
    repeat (3) @(negedge clk);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_mem_we", mem_we, 1'b0);
    checkBit("rst_io_we", io_we, 1'b0);
    checkBit("rst_m0_ack", m0_ack, 1'b0);
    checkBit("rst_m1_ack", m1_ack, 1'b0);
    checkBit("rst_owner", owner, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_io_addr", {27'h0, io_addr}, 32'h0);
    checkOutput("rst_io_wdata", io_wdata, 32'h0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkBit("idle_busy", busy, 1'b0);
    end

    $display("[TB] m0 write/read 0x10");
    q0.push_back(mkTx(1'b1, 32'h10, 32'hDEADBEEF));
    q0.push_back(mkTx(1'b0, 32'h10, 32'h0));
    runTraffic(0, 200);
    checkOutput("t2_readback", m0_rdata, 32'hDEADBEEF);

    $display("[TB] decode boundaries via m1");
    q1.push_back(mkTx(1'b1, 32'h02FFFFFC, 32'hA1A1A1A1));
    q1.push_back(mkTx(1'b1, 32'h03000004, 32'hB2B2B2B2));
    q1.push_back(mkTx(1'b1, 32'h03000000, 32'hC0FFEE00));
    q1.push_back(mkTx(1'b0, 32'h02FFFFFC, 32'h0));
    q1.push_back(mkTx(1'b0, 32'h03000000, 32'h0));
    runTraffic(1, 300);
    checkOutput("t3_io_read", m1_rdata, 32'hC0FFEE00);
    checkOutput("t3_io_reg4", io_arr[4], 32'hB2B2B2B2);
    checkOutput("t3_mem_top", mem_arr[10'h3FF], 32'hA1A1A1A1);

    $display("[TB] simultaneous requests, 4 each");
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mkTx(1'b1, 32'h40 + 32'(i * 4), 32'h0A000000 | 32'(i)));
      q1.push_back(mkTx(1'b0, 32'h40 + 32'(i * 4), 32'h0));
    end
    runTraffic(0, 300);
    checkOutput("t4_count", 32'(ack_order.size()), 32'd8);
    for (int i = 0; i < ack_order.size(); i++) begin
`ifdef RR_ARB_EN
      if (i > 0) checkBit("t4_alternate", ack_order[i] != ack_order[i-1], 1'b1);
`else
      checkOutput("t4_order", 32'(ack_order[i]), (i < 4) ? 32'h0 : 32'h1);
`endif
    end
`ifdef RR_ARB_EN
    checkBit("t4_latency", max_lat <= 6, 1'b1);
`endif

    $display("[TB] m0 drops req during ACCESS");
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0;
    @(negedge clk);
    checkBit("t6_busy_access", busy, 1'b1);
    m0_req = 1'b0;
    @(negedge clk);
    checkBit("t6_ack", m0_ack, 1'b1);
    checkOutput("t6_rdata", m0_rdata, refRead(32'h10));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBit("t6_no_extra_busy", busy, 1'b0);
      checkBit("t6_no_extra_ack", m0_ack, 1'b0);
    end

    $display("[TB] reset during ACCESS of a write to 0x20");
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h5A5A2020;
    @(negedge clk);
    checkBit("t5_strobe", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    checkBit("t5_strobe_removed", mem_we, 1'b0);
    checkBit("t5_busy", busy, 1'b0);
    @(negedge clk);
    checkBit("t5_no_ack", m0_ack, 1'b0);
    @(negedge clk);
    checkOutput("t5_mem_unchanged", mem_arr[8], refRead(32'h20));
    reset = 1'b0;
    ref_last = 1'b1;
    @(negedge clk);
    checkBit("t5_retry_strobe", mem_we, 1'b1);
    checkBit("t5_retry_owner", owner, 1'b0);
    @(negedge clk);
    checkBit("t5_retry_ack", m0_ack, 1'b1);
    m0_req = 1'b0;
    refWrite(32'h20, 32'h5A5A2020);
    @(negedge clk);
    checkBit("t5_idle", busy, 1'b0);
    checkOutput("t5_mem_written", mem_arr[8], refRead(32'h20));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      q0.push_back(randTx());
      q1.push_back(randTx());
    end
    runTraffic(3, 2000);
    checkOutput("rand_count", 32'(ack_order.size()), 32'd80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
